// File: rtl/vga_row_fetch.sv
// vga_row_fetch: VGA timing counters plus per-line row-word prefetch and double buffer.
// Define VGA_ROW_FETCH_BLANK_ON_UNDERRUN_EN to blank vdata on underrun (default: repeat prior row).
module vga_row_fetch #(
    parameter int HTOTAL  = 800,
    parameter int VTOTAL  = 525,
    parameter int HACTIVE = 640,
    parameter int VACTIVE = 480,
    parameter int ROW_DIV = 20,
    parameter int AW      = 5
) (
    input  logic          dclk,
    input  logic          clr_n,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [63:0]   mem_rdata,
    output logic [63:0]   vdata,
    output logic [9:0]    hc,
    output logic [9:0]    vc,
    output logic          line_valid,
    output logic          underrun
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LATE
    } state_t;

    localparam logic [9:0] HEND   = 10'(HTOTAL - 1);
    localparam logic [9:0] VEND   = 10'(VTOTAL - 1);
    localparam logic [9:0] VPRE   = 10'(VTOTAL - 2);
    localparam logic [9:0] HACT   = 10'(HACTIVE);
    localparam logic [9:0] VACT   = 10'(VACTIVE);
    localparam logic [9:0] SUBMAX = 10'(ROW_DIV - 1);
    // Row/remainder of target line 1 (the target right after reset or a frame wrap).
    localparam logic [9:0] T1ROW  = (ROW_DIV == 1) ? 10'd1 : 10'd0;
    localparam logic [9:0] T1SUB  = (ROW_DIV == 1) ? 10'd0 : 10'd1;

    state_t        state;
    state_t        state_nx;
    logic          h_end;
    logic          v_end;
    logic [9:0]    tline;
    logic          t_act;
    logic [9:0]    trow;
    logic [9:0]    tsub;
    logic [AW-1:0] row;
    logic [63:0]   shadow;
    logic [AW-1:0] srow;
    logic          svalid;
    logic          hit;
    logic          launch;

    assign h_end      = (hc == HEND);
    assign v_end      = (vc == VEND);
    assign tline      = v_end ? 10'd0 : vc + 10'd1;
    assign t_act      = (tline < VACT);
    assign row        = trow[AW-1:0];
    assign hit        = svalid && (srow == row);
    assign launch     = (state == IDLE) && (hc == HACT) && t_act && !hit;
    assign line_valid = (hc < HACT) && (vc < VACT);
    assign underrun   = h_end && t_act && !hit;

    // Horizontal and vertical raster counters.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hc <= '0;
            vc <= '0;
        end else if (h_end) begin
            hc <= '0;
            vc <= v_end ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    // Target row tracked incrementally: trow/tsub = divmod of next line by ROW_DIV.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            trow <= T1ROW;
            tsub <= T1SUB;
        end else if (h_end) begin
            if (v_end) begin
                trow <= T1ROW;
                tsub <= T1SUB;
            end else if (vc == VPRE) begin
                trow <= '0;
                tsub <= '0;
            end else if (tsub == SUBMAX) begin
                trow <= trow + 10'd1;
                tsub <= '0;
            end else begin
                tsub <= tsub + 10'd1;
            end
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Fetch FSM next-state logic; a late ack only closes the transfer.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (launch) state_nx = REQ;
            REQ: begin
                if (mem_ack)    state_nx = IDLE;
                else if (h_end) state_nx = LATE;
            end
            LATE: if (mem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Fetch FSM outputs.
    always_comb begin
        mem_req = (state != IDLE);
    end

    // Address launch and shadow capture; only an in-time ack fills the shadow.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            mem_addr <= '0;
            shadow   <= '0;
            srow     <= '0;
            svalid   <= 1'b0;
        end else if (launch) begin
            mem_addr <= row;
            svalid   <= 1'b0;
        end else if (state == REQ && mem_ack) begin
            shadow <= mem_rdata;
            srow   <= row;
            svalid <= 1'b1;
        end
    end

    // Present the buffered word at the line boundary.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            vdata <= '0;
        end else if (h_end && t_act) begin
            if (hit) vdata <= shadow;
`ifdef VGA_ROW_FETCH_BLANK_ON_UNDERRUN_EN
            else     vdata <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_vga_row_fetch.sv
// tb_vga_row_fetch: directed checks of timing, fetch, reuse, underrun and reset.
// Uses a reduced raster (80x105, 24 rows of 4 lines) to keep frames short.
module tb_vga_row_fetch;

    localparam int HT = 80;
    localparam int VT = 105;
    localparam int HA = 64;
    localparam int VA = 96;
    localparam int RD = 4;
    localparam int AW = 5;

    localparam logic [63:0] W0 = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] W1 = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;
`ifdef VGA_ROW_FETCH_BLANK_ON_UNDERRUN_EN
    localparam logic [63:0] HOLD = 64'h0;
`else
    localparam logic [63:0] HOLD = W0;
`endif

    logic          dclk = 1'b0;
    logic          clr_n = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [63:0]   mem_rdata = '0;
    logic [63:0]   vdata;
    logic [9:0]    hc;
    logic [9:0]    vc;
    logic          line_valid;
    logic          underrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wcnt = 0;
    bit block = 1'b0;
    bit man_pulse = 1'b0;
    logic [63:0] man_data = '0;

    vga_row_fetch #(
        .HTOTAL(HT), .VTOTAL(VT), .HACTIVE(HA),
        .VACTIVE(VA), .ROW_DIV(RD), .AW(AW)
    ) dut (
        .dclk(dclk), .clr_n(clr_n),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .vdata(vdata), .hc(hc), .vc(vc),
        .line_valid(line_valid), .underrun(underrun)
    );

    always #5 dclk = ~dclk;

    always @(posedge dclk) begin
        if (!clr_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Memory model: ack in the 4th req cycle; manual pulses override.
    always @(negedge dclk) begin
        if (man_pulse) begin
            mem_ack = 1'b1;
            mem_rdata = man_data;
        end else if (mem_req && !block && clr_n) begin
            wcnt = wcnt + 1;
            if (wcnt == 4) begin
                mem_ack = 1'b1;
                mem_rdata = {32'hA5A5_0000, 27'b0, mem_addr};
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        while (!(hc == 10'(h) && vc == 10'(v)) && n < 20000) begin
            step();
            n++;
        end
        if (n >= 20000) begin
            total++; bad++;
            $display("FAIL goto_%0d_%0d timeout: hc=%0d vc=%0d", h, v, hc, vc);
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (3) step();
        total++; if (hc !== 10'd0) begin bad++; $display("FAIL rst_hc got %0d want 0", hc); end
        total++; if (vc !== 10'd0) begin bad++; $display("FAIL rst_vc got %0d want 0", vc); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", mem_req); end
        total++; if (mem_addr !== 5'd0) begin bad++; $display("FAIL rst_addr got %0d want 0", mem_addr); end
        total++; if (vdata !== 64'h0) begin bad++; $display("FAIL rst_vdata got %h want 0", vdata); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got %b want 0", underrun); end
        total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL rst_lv got %b want 1", line_valid); end
        clr_n = 1'b1;
    endtask

    task automatic test_normal_fetch();
        goto(HA, 0);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL nf_req_early got %b want 0", mem_req); end
        step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL nf_req got %b want 1", mem_req); end
        total++; if (mem_addr !== 5'd0) begin bad++; $display("FAIL nf_addr got %0d want 0", mem_addr); end
        goto(HT - 1, 0);
        total++; if (vdata !== 64'h0) begin bad++; $display("FAIL nf_vdata0 got %h want 0", vdata); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL nf_ur0 got %b want 0", underrun); end
        step();
        total++; if (vdata !== W0) begin bad++; $display("FAIL nf_vdata1 got %h want %h", vdata, W0); end
    endtask

    task automatic test_counters();
        goto(HT - 1, 1);
        step();
        total++; if (hc !== 10'd0 || vc !== 10'd2) begin bad++; $display("FAIL cnt_hwrap got %0d/%0d want 0/2", hc, vc); end
        total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL cnt_lv_act got %b want 1", line_valid); end
        goto(HA, 2);
        total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL cnt_lv_hblank got %b want 0", line_valid); end
        goto(0, VA);
        total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL cnt_lv_vblank got %b want 0", line_valid); end
        goto(HT - 1, VT - 1);
        step();
        total++; if (hc !== 10'd0 || vc !== 10'd0) begin bad++; $display("FAIL cnt_vwrap got %0d/%0d want 0/0", hc, vc); end
        total++; if (cyc !== HT * VT) begin bad++; $display("FAIL cnt_frame_len got %0d want %0d", cyc, HT * VT); end
    endtask

    task automatic test_row_reuse();
        logic prev;
        int n;
        int ev;
        int ea;
        n = 0;
        prev = mem_req;
        for (int i = 0; i < HT * VT; i++) begin
            step();
            if (mem_req && !prev) begin
                n++;
                if (n <= 23) begin ev = RD * n - 1; ea = n; end
                else if (n == 24) begin ev = VT - 1; ea = 0; end
                else begin ev = -1; ea = -1; end
                total++;
                if (int'(vc) !== ev || int'(mem_addr) !== ea || int'(hc) !== HA + 1) begin
                    bad++;
                    $display("FAIL reuse_req%0d got vc=%0d addr=%0d hc=%0d want vc=%0d addr=%0d hc=%0d",
                             n, vc, mem_addr, hc, ev, ea, HA + 1);
                end
            end
            prev = mem_req;
        end
        total++; if (n !== 24) begin bad++; $display("FAIL reuse_count got %0d want 24", n); end
    endtask

    task automatic test_stray_ack();
        goto(10, 1);
        man_data = JUNK;
        man_pulse = 1'b1;
        step();
        man_pulse = 1'b0;
        total++; if (vdata !== W0) begin bad++; $display("FAIL stray_vdata got %h want %h", vdata, W0); end
        goto(HA + 1, 1);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL stray_req got %b want 0", mem_req); end
        goto(0, 2);
        total++; if (vdata !== W0) begin bad++; $display("FAIL stray_shadow got %h want %h", vdata, W0); end
    endtask

    task automatic test_underrun();
        goto(HA - 1, 3);
        block = 1'b1;
        goto(HA + 1, 3);
        total++; if (mem_req !== 1'b1 || mem_addr !== 5'd1) begin bad++; $display("FAIL ur_launch got req=%b addr=%0d want 1/1", mem_req, mem_addr); end
        goto(HT - 2, 3);
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_early got %b want 0", underrun); end
        step();
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_pulse3 got %b want 1", underrun); end
        step();
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_one_cycle got %b want 0", underrun); end
        total++; if (vdata !== HOLD) begin bad++; $display("FAIL ur_vdata4 got %h want %h", vdata, HOLD); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ur_late_req got %b want 1", mem_req); end
        goto(HA + 1, 4);
        total++; if (mem_req !== 1'b1 || mem_addr !== 5'd1) begin bad++; $display("FAIL ur_skip got req=%b addr=%0d want 1/1", mem_req, mem_addr); end
        goto(HA + 5, 4);
        man_data = JUNK;
        man_pulse = 1'b1;
        step();
        man_pulse = 1'b0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ur_late_drop got %b want 0", mem_req); end
        total++; if (vdata !== HOLD) begin bad++; $display("FAIL ur_discard got %h want %h", vdata, HOLD); end
        goto(HT - 1, 4);
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_pulse4 got %b want 1", underrun); end
        step();
        total++; if (vdata !== HOLD) begin bad++; $display("FAIL ur_vdata5 got %h want %h", vdata, HOLD); end
        block = 1'b0;
        goto(HA + 1, 5);
        total++; if (mem_req !== 1'b1 || mem_addr !== 5'd1) begin bad++; $display("FAIL ur_refetch got req=%b addr=%0d want 1/1", mem_req, mem_addr); end
        goto(0, 6);
        total++; if (vdata !== W1) begin bad++; $display("FAIL ur_recover got %h want %h", vdata, W1); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_clear got %b want 0", underrun); end
    endtask

    task automatic test_async_reset();
        goto(HA - 1, 7);
        block = 1'b1;
        goto(HA + 3, 7);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ar_req_pre got %b want 1", mem_req); end
        #1;
        clr_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ar_req_drop got %b want 0", mem_req); end
        total++; if (hc !== 10'd0 || vc !== 10'd0) begin bad++; $display("FAIL ar_cnt got %0d/%0d want 0/0", hc, vc); end
        man_data = JUNK;
        man_pulse = 1'b1;
        step();
        step();
        man_pulse = 1'b0;
        block = 1'b0;
        clr_n = 1'b1;
        total++; if (vdata !== 64'h0 || mem_addr !== 5'd0) begin bad++; $display("FAIL ar_state got vdata=%h addr=%0d want 0/0", vdata, mem_addr); end
        goto(HA + 1, 0);
        total++; if (mem_req !== 1'b1 || mem_addr !== 5'd0) begin bad++; $display("FAIL ar_refetch got req=%b addr=%0d want 1/0", mem_req, mem_addr); end
        goto(0, 1);
        total++; if (vdata !== W0) begin bad++; $display("FAIL ar_vdata got %h want %h", vdata, W0); end
    endtask

    initial begin
        test_reset();
        test_normal_fetch();
        test_counters();
        test_row_reuse();
        test_stray_ack();
        test_underrun();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
